ghost_dist_map: RTL and testbench

//  Builds and serves the per-cell proximity map that the ghost path chooser reads.

---
 rtl/ghost_dist_map.sv | 169 ++++++++++++++++
 tb/tb_ghost_dist_map.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ghost_dist_map.sv
`default_nettype none
// ============================================================================
// Module   : ghost_dist_map
// Brief    : Sweeps the grid into a 2048x8 proximity map (distance to pacman,
//            wall marker, previous-ghost marker) and serves registered reads.
// Revision : 1.0  initial release
// ============================================================================
module ghost_dist_map #(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int WALL_VAL = 255,
    parameter int PREV_VAL = 254
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [5:0] curr_pacman_x,
    input  logic [4:0] curr_pacman_y,
    input  logic [5:0] prev_ghost1_x,
    input  logic [4:0] prev_ghost1_y,
    input  logic [5:0] prev_ghost2_x,
    input  logic [4:0] prev_ghost2_y,
    output logic [5:0] wall_rdaddr_x,
    output logic [4:0] wall_rdaddr_y,
    input  logic       wall_bit,
    input  logic [5:0] rdaddr_x,
    input  logic [4:0] rdaddr_y,
    output logic [7:0] data,
    output logic       ready
);

    localparam logic [1:0] c_LATCH = 2'd0;
    localparam logic [1:0] c_SWEEP = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;
    localparam logic [1:0] c_VALID = 2'd3;

    localparam logic [5:0] c_X_LAST = 6'(GRID_W - 1);
    localparam logic [4:0] c_Y_LAST = 5'(GRID_H - 1);
    localparam logic [7:0] c_WALL   = 8'(WALL_VAL);
    localparam logic [7:0] c_PREV   = 8'(PREV_VAL);
    localparam logic [7:0] c_SAT    = 8'd253;

    logic [1:0] r_state;
    logic [1:0] w_next_state;

    logic [5:0] r_pac_x, r_g1_x, r_g2_x;
    logic [4:0] r_pac_y, r_g1_y, r_g2_y;
    logic [5:0] r_cnt_x;
    logic [4:0] r_cnt_y;
    logic       r_wr_en;
    logic [5:0] r_wr_x;
    logic [4:0] r_wr_y;
    logic [7:0] r_data;
    logic [7:0] r_mem [0:2047];

    logic       w_change;
    logic       w_last;
    logic [6:0] w_dx, w_dy, w_adx, w_ady;
    logic [7:0] w_sum;
    logic [7:0] w_wr_data;
    logic       w_off_grid;

    assign w_change = (curr_pacman_x != r_pac_x) || (curr_pacman_y != r_pac_y) ||
                      (prev_ghost1_x != r_g1_x)  || (prev_ghost1_y != r_g1_y)  ||
                      (prev_ghost2_x != r_g2_x)  || (prev_ghost2_y != r_g2_y);
    assign w_last   = (r_cnt_x == c_X_LAST) && (r_cnt_y == c_Y_LAST);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= c_LATCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_LATCH: w_next_state = c_SWEEP;
            c_SWEEP: begin
                if (w_change)    w_next_state = c_LATCH;
                else if (w_last) w_next_state = c_FLUSH;
            end
            c_FLUSH: w_next_state = w_change ? c_LATCH : c_VALID;
            c_VALID: if (w_change) w_next_state = c_LATCH;
            default: w_next_state = c_LATCH;
        endcase
    end

    always_comb begin
        ready         = (r_state == c_VALID);
        wall_rdaddr_x = r_cnt_x;
        wall_rdaddr_y = r_cnt_y;
    end

    // Reset value 63/31 is off-grid, so the first comparison always sees a change
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_pac_x <= 6'd63;
            r_pac_y <= 5'd31;
            r_g1_x  <= 6'd63;
            r_g1_y  <= 5'd31;
            r_g2_x  <= 6'd63;
            r_g2_y  <= 5'd31;
            r_cnt_x <= 6'd0;
            r_cnt_y <= 5'd0;
            r_wr_en <= 1'b0;
            r_wr_x  <= 6'd0;
            r_wr_y  <= 5'd0;
        end else begin
            if (r_state == c_LATCH) begin
                r_pac_x <= curr_pacman_x;
                r_pac_y <= curr_pacman_y;
                r_g1_x  <= prev_ghost1_x;
                r_g1_y  <= prev_ghost1_y;
                r_g2_x  <= prev_ghost2_x;
                r_g2_y  <= prev_ghost2_y;
                r_cnt_x <= 6'd0;
                r_cnt_y <= 5'd0;
            end else if ((r_state == c_SWEEP) && !w_last) begin
                if (r_cnt_x == c_X_LAST) begin
                    r_cnt_x <= 6'd0;
                    r_cnt_y <= r_cnt_y + 5'd1;
                end else begin
                    r_cnt_x <= r_cnt_x + 6'd1;
                end
            end
            // Wall ROM answers one cycle later, so the address is carried along
            r_wr_en <= (r_state == c_SWEEP);
            r_wr_x  <= r_cnt_x;
            r_wr_y  <= r_cnt_y;
        end
    end

    always_comb begin
        w_dx  = {1'b0, r_wr_x} - {1'b0, r_pac_x};
        w_dy  = {2'b00, r_wr_y} - {2'b00, r_pac_y};
        w_adx = w_dx[6] ? (7'd0 - w_dx) : w_dx;
        w_ady = w_dy[6] ? (7'd0 - w_dy) : w_dy;
        w_sum = {1'b0, w_adx} + {1'b0, w_ady};
        if (wall_bit) begin
            w_wr_data = c_WALL;
        end else if (((r_wr_x == r_g1_x) && (r_wr_y == r_g1_y)) ||
                     ((r_wr_x == r_g2_x) && (r_wr_y == r_g2_y))) begin
            w_wr_data = c_PREV;
        end else begin
            w_wr_data = (w_sum > c_SAT) ? c_SAT : w_sum;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (r_wr_en) begin
            r_mem[{r_wr_y, r_wr_x}] <= w_wr_data;
        end
    end

    assign w_off_grid = (32'(rdaddr_x) >= 32'(GRID_W)) || (32'(rdaddr_y) >= 32'(GRID_H));

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_data <= c_WALL;
        end else begin
            r_data <= w_off_grid ? c_WALL : r_mem[{rdaddr_y, rdaddr_x}];
        end
    end

    assign data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_ghost_dist_map.sv
`default_nettype none
// ============================================================================
// Module   : tb_ghost_dist_map
// Brief    : Scoreboard bench for ghost_dist_map with a cell-rule reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ghost_dist_map;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [5:0] wall_rdaddr_x, rdaddr_x;
    logic [4:0] wall_rdaddr_y, rdaddr_y;
    logic       wall_bit = 1'b0;
    logic [7:0] data;
    logic       ready;

    int px, py, g1x, g1y, g2x, g2y;
    bit wall_map [0:31][0:63];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {int x; int y; int exp;} rd_t;
    rd_t  exp_q [$];
    logic rd_req = 1'b0;
    logic rd_pend = 1'b0;

    ghost_dist_map dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .curr_pacman_x (6'(px)),
        .curr_pacman_y (5'(py)),
        .prev_ghost1_x (6'(g1x)),
        .prev_ghost1_y (5'(g1y)),
        .prev_ghost2_x (6'(g2x)),
        .prev_ghost2_y (5'(g2y)),
        .wall_rdaddr_x (wall_rdaddr_x),
        .wall_rdaddr_y (wall_rdaddr_y),
        .wall_bit      (wall_bit),
        .rdaddr_x      (rdaddr_x),
        .rdaddr_y      (rdaddr_y),
        .data          (data),
        .ready         (ready)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Wall ROM: one-cycle read latency
    always @(posedge CLOCK_50) wall_bit <= wall_map[wall_rdaddr_y][wall_rdaddr_x];

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int model(input int x, input int y);
        int d;
        if (x >= 40 || y >= 30) return 255;
        if (wall_map[y][x]) return 255;
        if ((x == g1x && y == g1y) || (x == g2x && y == g2y)) return 254;
        d = iabs(x - px) + iabs(y - py);
        return (d > 253) ? 253 : d;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: data for a read issued in cycle n appears after edge n+1
    always @(posedge CLOCK_50) rd_pend <= rd_req;
    always @(negedge CLOCK_50) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read_data", int'(data), -1);
            end else begin
                rd_t e;
                e = exp_q.pop_front();
                check($sformatf("read(%0d,%0d)", e.x, e.y), int'(data), e.exp);
            end
        end
    end

    task automatic rd(input int x, input int y);
        rd_t e;
        rdaddr_x = 6'(x);
        rdaddr_y = 5'(y);
        rd_req   = 1'b1;
        e.x = x; e.y = y; e.exp = model(x, y);
        exp_q.push_back(e);
        @(posedge CLOCK_50); #1;
        rd_req = 1'b0;
    endtask

    task automatic drain();
        repeat (2) @(posedge CLOCK_50);
        #1;
    endtask

    // Counts edges until ready is seen high; -1 reports a timeout
    task automatic wait_ready(input int exp_n, input string name);
        int n;
        bit got;
        n = 0; got = 0;
        while (n < 3000 && !got) begin
            @(posedge CLOCK_50); #1;
            n++;
            if (ready) got = 1;
        end
        check(name, got ? n : -1, exp_n);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        rdaddr_x = '0; rdaddr_y = '0;
        px = 20; py = 20; g1x = 16; g1y = 13; g2x = 23; g2y = 13;
        foreach (wall_map[i, j]) wall_map[i][j] = 1'b0;
        wall_map[19][20] = 1'b1;

        repeat (2) @(posedge CLOCK_50);
        #1;
        check("reset_ready", int'(ready), 0);
        check("reset_data", int'(data), 255);
        check("reset_wall_rdaddr", int'({wall_rdaddr_y, wall_rdaddr_x}), 0);
        @(posedge CLOCK_50); #1;
        reset = 1'b0;

        // Initial sweep
        wait_ready(1202, "initial_latency");
        rd(20, 20); rd(0, 0); rd(16, 13); rd(23, 13);
        rd(20, 19); rd(20, 21);
        drain();

        // Pacman moves while valid
        px = 5; py = 5;
        @(posedge CLOCK_50); #1;
        check("move_ready_drop", int'(ready), 0);
        wait_ready(1202, "move_latency");
        rd(5, 5); rd(20, 20);
        drain();

        // Abort mid-sweep by moving ghost1's previous cell
        g2y = 14;
        repeat (601) @(posedge CLOCK_50);
        #1;
        check("mid_sweep_ready", int'(ready), 0);
        g1x = 10; g1y = 10;
        wait_ready(1203, "abort_latency");
        rd(10, 10); rd(16, 13); rd(23, 13); rd(23, 14);
        drain();

        // Off-grid reads, back to back
        rd(63, 13); rd(39, 13); rd(0, 31); rd(40, 29); rd(39, 29);
        drain();

        // Reset mid-sweep
        px = 30; py = 25;
        repeat (301) @(posedge CLOCK_50);
        #1;
        reset = 1'b1;
        #1;
        check("midsweep_reset_ready", int'(ready), 0);
        check("midsweep_reset_data", int'(data), 255);
        repeat (3) @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        wait_ready(1202, "post_reset_latency");
        rd(30, 25); rd(0, 0); rd(20, 19);
        drain();

        // Randomized maps and positions
        for (int r = 0; r < 6; r++) begin
            int opx, opy, og1x, og1y, og2x, og2y;
            opx = px; opy = py; og1x = g1x; og1y = g1y; og2x = g2x; og2y = g2y;
            foreach (wall_map[i, j]) wall_map[i][j] = 1'b0;
            for (int k = 0; k < 80; k++)
                wall_map[$urandom_range(29, 0)][$urandom_range(39, 0)] = 1'b1;
            px  = $urandom_range(39, 0); py  = $urandom_range(29, 0);
            g1x = $urandom_range(39, 0); g1y = $urandom_range(29, 0);
            g2x = $urandom_range(39, 0); g2y = $urandom_range(29, 0);
            if (r == 0) begin
                g2x = px; g2y = py;
                wall_map[py][px] = 1'b0;
            end
            if (r == 1) wall_map[g1y][g1x] = 1'b1;
            if (px == opx && py == opy && g1x == og1x && g1y == og1y &&
                g2x == og2x && g2y == og2y)
                px = (px + 1) % 40;
            wait_ready(1203, $sformatf("rand%0d_latency", r));
            rd(px, py); rd(g1x, g1y); rd(g2x, g2y);
            for (int k = 0; k < 30; k++) begin
                if ($urandom_range(3, 0) == 0)
                    rd($urandom_range(63, 0), $urandom_range(31, 0));
                else
                    rd($urandom_range(39, 0), $urandom_range(29, 0));
            end
            drain();
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
